// File: rtl/pl_pc_gen_if.sv
// Bundles the pl_pc_gen control inputs, redirect targets and fetch/trap outputs.
// master drives the control and target inputs; slave is the PC generator.
interface pl_pc_gen_if;
  logic        halt;
  logic        dbg_imem_we;
  logic        wpcir;
  logic [1:0]  pcsrc;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic [31:0] jalrpc;
  logic        irq;
  logic        irq_en;
  logic        mret;
  logic [31:0] mepc_in;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] epc;
  logic        irq_taken;
  logic        flush_if;
  logic        in_handler;

  modport master (
    output halt, dbg_imem_we, wpcir, pcsrc, bpc, jpc, jalrpc,
           irq, irq_en, mret, mepc_in,
    input  pc, pc4, epc, irq_taken, flush_if, in_handler
  );

  modport slave (
    input  halt, dbg_imem_we, wpcir, pcsrc, bpc, jpc, jalrpc,
           irq, irq_en, mret, mepc_in,
    output pc, pc4, epc, irq_taken, flush_if, in_handler
  );
endinterface

// File: rtl/pl_pc_gen.sv
// Fetch PC generator: next-PC select, load-use stall, interrupt take and MRET return.
// Redirects show up on pc one edge after the deciding cycle; halt/debug writes freeze everything.
module pl_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        rst,
  pl_pc_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    PENDING = 2'b01,
    HANDLER = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pc4;
  logic [31:0] npc;
  logic        hold;
  logic        irq_req;
  logic        take;
  logic        do_mret;

  assign pc4  = pc_q + 32'd4;
  assign hold = bus.halt | bus.dbg_imem_we;

  always_comb begin
    npc = pc4;
    unique case (bus.pcsrc)
      2'b00: npc = pc4;
      2'b01: npc = bus.bpc    & 32'hFFFF_FFFC;
      2'b10: npc = bus.jpc    & 32'hFFFF_FFFC;
      2'b11: npc = bus.jalrpc & 32'hFFFF_FFFC;
      default: npc = pc4;
    endcase
  end

  // Request is only visible outside the handler; mret only inside it, so the two never overlap.
  assign irq_req = bus.irq & bus.irq_en & ((state_q == RUN) || (state_q == PENDING));
  assign do_mret = ~rst & ~hold & bus.mret & (state_q == HANDLER);
  assign take    = ~rst & ~hold & irq_req & bus.wpcir;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    if (!hold) begin
      unique case (state_q)
        RUN, PENDING: begin
          if (take) begin
            state_d = HANDLER;
            pc_d    = TRAP_VEC;
            epc_d   = npc;
          end else begin
            state_d = irq_req ? PENDING : RUN;
            if (bus.wpcir) pc_d = npc;
          end
        end
        HANDLER: begin
          if (do_mret) begin
            state_d = RUN;
            pc_d    = bus.mepc_in & 32'hFFFF_FFFC;
          end else if (bus.wpcir) begin
            pc_d = npc;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      epc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc4        = pc4;
  assign bus.epc        = epc_q;
  assign bus.irq_taken  = take;
  assign bus.flush_if   = take | do_mret;
  assign bus.in_handler = (state_q == HANDLER);

endmodule

// File: tb/tb_pl_pc_gen.sv
// Directed scenarios plus randomized cycles for pl_pc_gen, checked against a cycle-level reference model.
module tb_pl_pc_gen;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TVEC   = 32'h0000_0008;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference state: PENDING behaves exactly like RUN, so only "in handler" is tracked.
  logic [31:0] m_pc, m_epc;
  logic        m_hdl;

  pl_pc_gen_if bus ();

  pl_pc_gen #(.RESET_PC(RST_PC), .TRAP_VEC(TVEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_npc();
    logic [31:0] t;
    case (bus.pcsrc)
      2'd1:    t = bus.bpc;
      2'd2:    t = bus.jpc;
      2'd3:    t = bus.jalrpc;
      default: return m_pc + 32'd4;
    endcase
    return {t[31:2], 2'b00};
  endfunction

  function automatic logic m_hold();
    return bus.halt | bus.dbg_imem_we;
  endfunction

  function automatic logic m_take();
    return !rst && !m_hold() && !m_hdl && bus.irq && bus.irq_en && bus.wpcir;
  endfunction

  function automatic logic m_ret();
    return !rst && !m_hold() && m_hdl && bus.mret;
  endfunction

  // Apply one edge of the rules in priority order: rst, hold, mret, take, stall, select.
  task automatic m_edge();
    logic [31:0] mep;
    if (rst) begin
      m_pc = RST_PC; m_epc = 32'h0; m_hdl = 1'b0;
    end else if (m_hold()) begin
    end else if (m_ret()) begin
      mep = bus.mepc_in;
      m_pc = {mep[31:2], 2'b00}; m_hdl = 1'b0;
    end else if (m_take()) begin
      m_epc = m_npc(); m_pc = TVEC; m_hdl = 1'b1;
    end else if (bus.wpcir) begin
      m_pc = m_npc();
    end
  endtask

  // Check all outputs against the model mid-cycle, then advance one edge.
  task automatic step();
    @(negedge clk);
    chk1 ("irq_taken",  bus.irq_taken,  m_take());
    chk1 ("flush_if",   bus.flush_if,   m_take() | m_ret());
    chk32("pc4",        bus.pc4,        m_pc + 32'd4);
    chk32("pc",         bus.pc,         m_pc);
    chk32("epc",        bus.epc,        m_epc);
    chk1 ("in_handler", bus.in_handler, m_hdl);
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle();
    bus.halt = 0; bus.dbg_imem_we = 0; bus.wpcir = 1; bus.pcsrc = 2'd0;
    bus.irq = 0; bus.irq_en = 1; bus.mret = 0; rst = 0;
  endtask

  task automatic jump(input logic [31:0] a);
    bus.pcsrc = 2'd2; bus.jpc = a; step(); bus.pcsrc = 2'd0;
  endtask

  initial begin
    rst = 1;
    idle(); rst = 1;
    bus.bpc = '0; bus.jpc = '0; bus.jalrpc = '0; bus.mepc_in = '0;
    @(posedge clk); @(posedge clk); m_edge(); #1;
    chk32("reset_pc", bus.pc, 32'h0);
    chk32("reset_epc", bus.epc, 32'h0);
    chk1 ("reset_hdl", bus.in_handler, 1'b0);

    // Sequential fetch after reset.
    idle();
    chk32("seq_pc4_at0", bus.pc4, 32'h4);
    step(); chk32("seq_pc1", bus.pc, 32'h4);
    step(); chk32("seq_pc2", bus.pc, 32'h8);
    step(); chk32("seq_pc3", bus.pc, 32'hC);

    // JALR target alignment and pc+4 wrap.
    jump(32'h100);
    bus.pcsrc = 2'd3; bus.jalrpc = 32'h203; step(); bus.pcsrc = 2'd0;
    chk32("jalr_align", bus.pc, 32'h200);
    jump(32'hFFFF_FFFC);
    chk32("wrap_pc4", bus.pc4, 32'h0);
    step(); chk32("wrap_pc", bus.pc, 32'h0);

    // Interrupt deferred by a stall, taken when wpcir rises.
    jump(32'h40);
    bus.irq = 1; bus.wpcir = 0;
    step(); chk32("stall_pc1", bus.pc, 32'h40);
    step(); chk32("stall_pc2", bus.pc, 32'h40);
    bus.wpcir = 1; #1;
    chk1("take_pulse", bus.irq_taken, 1'b1);
    chk1("take_flush", bus.flush_if, 1'b1);
    step();
    chk32("take_epc", bus.epc, 32'h44);
    chk32("take_pc", bus.pc, 32'h8);
    chk1 ("take_hdl", bus.in_handler, 1'b1);

    // mret wins over irq in the handler, then irq is taken again.
    bus.mret = 1; bus.mepc_in = 32'h45; #1;
    chk1("mret_flush", bus.flush_if, 1'b1);
    chk1("mret_no_take", bus.irq_taken, 1'b0);
    step(); bus.mret = 0;
    chk32("mret_pc", bus.pc, 32'h44);
    chk1 ("mret_hdl", bus.in_handler, 1'b0);
    step();
    chk32("retake_pc", bus.pc, 32'h8);
    chk32("retake_epc", bus.epc, 32'h48);

    // Pending interrupt withdrawn before the stall clears.
    bus.irq = 0; bus.mret = 1; bus.mepc_in = 32'h80; step(); bus.mret = 0;
    bus.irq = 1; bus.wpcir = 0; step();
    bus.irq = 0; step();
    bus.wpcir = 1; #1;
    chk1("drop_no_take", bus.irq_taken, 1'b0);
    step();
    chk32("drop_pc", bus.pc, 32'h84);
    chk32("drop_epc", bus.epc, 32'h48);
    chk1 ("drop_hdl", bus.in_handler, 1'b0);

    // Halt and debug write freeze pc, epc and state with no pulses.
    bus.halt = 1; bus.irq = 1; bus.pcsrc = 2'd1; bus.bpc = 32'h300; #1;
    chk1("halt_no_take", bus.irq_taken, 1'b0);
    chk1("halt_no_flush", bus.flush_if, 1'b0);
    step(); step();
    chk32("halt_pc", bus.pc, 32'h84);
    chk32("halt_epc", bus.epc, 32'h48);
    bus.halt = 0; bus.dbg_imem_we = 1; step();
    chk32("dbg_pc", bus.pc, 32'h84);
    bus.dbg_imem_we = 0; step();
    chk1 ("post_halt_hdl", bus.in_handler, 1'b1);

    // Reset inside the handler discards it.
    rst = 1; bus.mret = 1; #1;
    chk1("rst_no_flush", bus.flush_if, 1'b0);
    step(); rst = 0; bus.mret = 0;
    chk32("rst_pc", bus.pc, RST_PC);
    chk1 ("rst_hdl", bus.in_handler, 1'b0);
    chk32("rst_epc", bus.epc, 32'h0);

    // Randomized cycles against the model.
    for (int i = 0; i < 1500; i++) begin
      rst             = ($urandom_range(0, 99) < 2);
      bus.halt        = ($urandom_range(0, 99) < 8);
      bus.dbg_imem_we = ($urandom_range(0, 99) < 4);
      bus.wpcir       = ($urandom_range(0, 99) < 75);
      bus.pcsrc       = 2'($urandom_range(0, 3));
      bus.bpc         = $urandom;
      bus.jpc         = $urandom;
      bus.jalrpc      = $urandom;
      bus.irq         = ($urandom_range(0, 99) < 30);
      bus.irq_en      = ($urandom_range(0, 99) < 70);
      bus.mret        = ($urandom_range(0, 99) < 25);
      bus.mepc_in     = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pl_pc_gen.md
PL_PC_GEN -- requirements
Module: pl_pc_gen

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: TRAP_VEC, 32'h0000_0008, interrupt handler entry address.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 halt  in  1  freeze request; PC and FSM hold.
REQ-006 dbg_imem_we  in  1  debug instruction-memory write; PC and FSM hold.
REQ-007 wpcir  in  1  PC write enable; 0 means load-use stall.
REQ-008 pcsrc  in  2  next-PC select: 00 pc+4, 01 bpc, 10 jpc, 11 jalrpc.
REQ-009 bpc, jpc, jalrpc  in  32 each  branch, JAL and JALR targets from ID.
REQ-010 irq  in  1  level-sensitive external interrupt request.
REQ-011 irq_en  in  1  global interrupt enable (mstatus.MIE).
REQ-012 mret  in  1  MRET decoded in ID this cycle.
REQ-013 mepc_in  in  32  return address for MRET.
REQ-014 pc  out  32  registered fetch address driven to the IF stage.
REQ-015 pc4  out  32  combinational pc+4.
REQ-016 epc  out  32  registered interrupted-PC capture, written to mepc.
REQ-017 irq_taken  out  1  combinational one-cycle pulse in the interrupt-take cycle.
REQ-018 flush_if  out  1  combinational; IF/ID loads a NOP at this edge.
REQ-019 in_handler  out  1  registered; high while FSM is in HANDLER.

Function
REQ-020 FSM states: RUN, PENDING, HANDLER. The FSM SHALL be 2-bit encoded, and the unused encoding SHALL return to RUN.
REQ-021 Per-cycle priority SHALL be: rst > hold (halt | dbg_imem_we) > mret > interrupt take > stall (!wpcir) > pcsrc select.
REQ-022 Hold: pc, epc and FSM state SHALL be unchanged, and irq_taken and flush_if SHALL be 0.
REQ-023 npc SHALL be pc4 when pcsrc=00 and the selected target when pcsrc is 01, 10 or 11. The selected target SHALL have bits[1:0] forced to 00.
REQ-024 pc4 SHALL wrap modulo 2^32, so that 32'hFFFF_FFFC + 4 = 0.
REQ-025 Normal update: when wpcir=1 and no take or mret applies, pc SHALL load npc at the edge. When wpcir=0, pc SHALL hold.
REQ-026 Interrupt request condition: irq & irq_en in RUN or PENDING.
REQ-027 Take condition: the request condition holds and wpcir=1.
REQ-028 On take: epc SHALL load npc, pc SHALL load TRAP_VEC, irq_taken=1, flush_if=1, and the state SHALL become HANDLER.
REQ-029 RUN to PENDING: the request condition holds and wpcir=0. pc SHALL hold.
REQ-030 PENDING back to RUN without a take: irq or irq_en deasserts before the take condition holds. No side effects SHALL occur.
REQ-031 HANDLER: irq SHALL be ignored. pc SHALL follow REQ-025.
REQ-032 MRET in HANDLER: pc SHALL load {mepc_in[31:2],2'b00}, flush_if=1, and the state SHALL become RUN. wpcir SHALL be ignored for this cycle.
REQ-033 MRET in RUN or PENDING SHALL be ignored and treated as a normal cycle.
REQ-034 Latency: a redirect SHALL appear on pc exactly one edge after the deciding cycle, with zero bubbles beyond flush_if.
REQ-035 Irq and mret in the same HANDLER cycle: mret SHALL win. The state SHALL go to RUN, and irq SHALL be re-evaluated the next cycle.

Reset
REQ-036 On rst=1 at an edge: pc=RESET_PC, epc=0, state=RUN, in_handler=0.
REQ-037 While rst=1: irq_taken=0 and flush_if=0. All other inputs SHALL be ignored.
REQ-038 A reset asserted in PENDING or HANDLER SHALL discard the pending or active interrupt. No epc capture SHALL occur.

Verification
REQ-039 Reset then 3 idle cycles with pcsrc=00, wpcir=1: pc SHALL read 0, 4, 8, 12. pc4 SHALL read 4 when pc=0.
REQ-040 pc=0x100, pcsrc=11, jalrpc=0x203: pc SHALL read 0x200 next cycle. In a separate case, pc=0xFFFF_FFFC with pcsrc=00 SHALL give pc=0.
REQ-041 pc=0x40, irq=1, irq_en=1, wpcir=0 for 2 cycles, then wpcir=1: pc SHALL hold 0x40 for 2 cycles. Then irq_taken=1, flush_if=1, epc=0x44, pc=0x8, and in_handler=1.
REQ-042 In HANDLER, irq=1 and mret=1 with mepc_in=0x45: pc SHALL read 0x44 next cycle, with flush_if=1 and state RUN. Then, with irq still 1 and wpcir=1, a re-take SHALL occur, giving pc=0x8.
REQ-043 In PENDING, irq drops before wpcir rises: no take SHALL occur, epc SHALL be unchanged, and the state SHALL be RUN.
REQ-044 halt=1 together with irq=1 and pcsrc=01: pc, state and epc SHALL be frozen, with no pulses. Separately, rst=1 in HANDLER SHALL give pc=RESET_PC and in_handler=0.
